dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the slave end of the MEM-stage load/store interface.
//  - Owns the data RAM.
//  - Services one CPU load or store at a time with a valid/ready request and a
//    one-cycle response pulse.
//  - Arbitrates a low-priority external debug read port (16-bit address) into
//    the same RAM.
//  - Sits between the MEM stage and the board-level data readout.
// PARAMETERS
//  XLEN        32     data width (from config)
//  DEPTH_LOG2  10     RAM depth = 2**DEPTH_LOG2 words
// PORTS
//  clk           in   1     system clock, rising edge
//  rst           in   1     asynchronous, active-low reset
//  req_valid     in   1     CPU request present
//  req_ready     out  1     responder accepts request this cycle
//  req_addr      in   XLEN  byte address
//  load_flag     in   5     one-hot {LHU,LBU,LW,LH,LB}, bit0=LB
//  store_flag    in   3     one-hot {SW,SH,SB}, bit0=SB
//  store_data    in   XLEN  store data; low bytes used for SB/SH
//  resp_valid    out  1     one-cycle response pulse
//  resp_data     out  XLEN  extended load data; 0 for store/nop
//  dbg_rd_en     in   1     external read request (pulse or level)
//  dbg_rd_addr   in   16    external word address
//  dbg_rd_valid  out  1     one-cycle pulse, dbg_rd_data valid
//  dbg_rd_data   out  XLEN  raw RAM word
//  resp_err      out  1     misalign error (DMEM_MISALIGN_CHK_EN only)
// BEHAVIOUR
//  Reset:
//  - All outputs 0; req_ready 0 while rst low; FSM in IDLE; debug-pending flag cleared.
//  - RAM contents are not cleared.
//  - Reset asserted mid-operation aborts the transaction; no response pulse follows.
//  FSM states: IDLE, LD, ST, DBG.
//  - req_ready = 1 only in IDLE (and rst high).
//  - IDLE, req_valid=1: accept at edge E0.
//    - store_flag != 0: RAM byte-write at E0 -> ST.
//    - else load_flag != 0: RAM read -> LD.
//    - else (nop): -> ST, resp_data=0.
//  - IDLE, no req, debug pending or dbg_rd_en: -> DBG.
//  - LD/ST/DBG -> IDLE unconditionally at E1.
//  - resp_valid/resp_data/dbg_rd_valid/dbg_rd_data are registered at E1.
//    High exactly the cycle after E1; cleared at the next edge.
//  Latency and throughput:
//  - Acceptance-to-response latency is 2 edges.
//  - Max throughput is 1 request per 2 cycles.
//  Simultaneous CPU request and debug read in IDLE:
//  - CPU wins.
//  - dbg_rd_addr is latched into a pending register; served at the first IDLE cycle with no req_valid.
//  - A new dbg_rd_en while a request is pending overwrites the pending address; only one response is produced.
//  Load and store flags both nonzero: treated as store; load ignored.
//  Addressing:
//  - Word index = req_addr[DEPTH_LOG2+1:2]; higher bits are ignored (wrap-around).
//  - Debug index = dbg_rd_addr[DEPTH_LOG2-1:0].
//  Lane selection and extension:
//  - LB/LBU, SB: lane = addr[1:0].
//  - LH/LHU, SH: halfword = addr[1].
//  - LB, LH: sign-extend to XLEN. LBU, LHU: zero-extend.
//  - LW/SW: full word.
// CONFIGURATION
//  DMEM_MISALIGN_CHK_EN defined:
//  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is still accepted.
//  - No RAM write occurs; resp_data=0; resp_err pulses together with resp_valid.
//  DMEM_MISALIGN_CHK_EN undefined:
//  - Low address bits are silently ignored as above.
//  - resp_err is tied to 0.
// STRUCTURE
//  Shared package dmem_pkg:
//  - Load/store one-hot bit indices (LB..LHU, SB..SW).
//  - FSM state encodings.
//  - Byte-enable generation function.
//  Sub-module dmem_byte_ram:
//  - Single-port synchronous RAM, 4 byte-write enables, registered read.
//  - Instanced once.
//  - Address/data muxed between the CPU path and the debug path by the FSM.
// TESTING
//  1. Reset low mid-LD -> resp_valid never pulses; all outputs 0; a prior SW value is retained after reset.
//  2. SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_data=0xDEADBEEF 2 edges after LW accept.
//     req_ready=0 in between.
//  3. SB 0x80 @0x13; then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80AD.
//  4. dbg_rd_en with dbg_rd_addr=4, same cycle as a CPU LW @0x20:
//     - CPU responds first.
//     - dbg_rd_valid follows with word[4].
//  5. LW @0x4000 with DEPTH_LOG2=10 -> returns word[0] (wrap-around).
//  6. With DMEM_MISALIGN_CHK_EN: SH @0x11 -> resp_err=1, resp_data=0, RAM unchanged.
//     Without it: writes halfword lane 0 at word 0x10.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared definitions for the data-memory responder
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  // One-hot bit positions of load_flag {LHU,LBU,LW,LH,LB}
  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;

  // One-hot bit positions of store_flag {SW,SH,SB}
  localparam int SF_SB = 0;
  localparam int SF_SH = 1;
  localparam int SF_SW = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LD   = 2'd1,
    S_ST   = 2'd2,
    S_DBG  = 2'd3
  } state_e;

  // Byte-lane write enables for a store; widest size wins if several bits set
  function automatic logic [3:0] byte_en(input logic [2:0] sf, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    if (sf[SF_SW])      be = 4'b1111;
    else if (sf[SF_SH]) be = a[1] ? 4'b1100 : 4'b0011;
    else if (sf[SF_SB]) be = 4'b0001 << a;
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_byte_ram.sv
// ============================================================================
// dmem_byte_ram : single-port synchronous RAM, per-byte write enables,
//                 registered read. Contents are never reset.
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module dmem_byte_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : MEM-stage load/store slave owning the data RAM, with a
//                  low-priority debug read port. Optional: DMEM_MISALIGN_CHK_EN
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [4:0]      load_flag,
  input  logic [2:0]      store_flag,
  input  logic [XLEN-1:0] store_data,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  input  logic            dbg_rd_en,
  input  logic [15:0]     dbg_rd_addr,
  output logic            dbg_rd_valid,
  output logic [XLEN-1:0] dbg_rd_data,
  output logic            resp_err
);

  state_e                state_q, state_d;
  logic [4:0]            lflag_q, lflag_d;
  logic [1:0]            lane_q, lane_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;
  logic [DEPTH_LOG2-1:0] pend_addr_q, pend_addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]       resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  dbg_valid_q, dbg_valid_d;
  logic [XLEN-1:0]       dbg_data_q, dbg_data_d;

  logic                  ram_en;
  logic [XLEN/8-1:0]     ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [XLEN-1:0]       ram_wdata;
  logic [XLEN-1:0]       ram_rdata;

  logic [DEPTH_LOG2-1:0] cpu_idx;
  logic [DEPTH_LOG2-1:0] dbg_idx;
  logic                  misalign;
  logic [XLEN-1:0]       st_wdata;
  logic [XLEN-1:0]       ld_ext;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  unused_addr_bits;

  // Upper address bits are deliberately dropped so accesses wrap around the RAM
  assign cpu_idx          = req_addr[DEPTH_LOG2+1:2];
  assign dbg_idx          = dbg_rd_addr[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^{req_addr[XLEN-1:DEPTH_LOG2+2], dbg_rd_addr[15:DEPTH_LOG2]};

`ifdef DMEM_MISALIGN_CHK_EN
  always_comb begin
    misalign = 1'b0;
    if (|store_flag)
      misalign = (store_flag[SF_SW] & (|req_addr[1:0])) |
                 (~store_flag[SF_SW] & store_flag[SF_SH] & req_addr[0]);
    else
      misalign = (load_flag[LD_LW] & (|req_addr[1:0])) |
                 ((load_flag[LD_LH] | load_flag[LD_LHU]) & req_addr[0]);
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    st_wdata = store_data;
    if (!store_flag[SF_SW]) begin
      if (store_flag[SF_SH])      st_wdata = {(XLEN/16){store_data[15:0]}};
      else if (store_flag[SF_SB]) st_wdata = {(XLEN/8){store_data[7:0]}};
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = ram_rdata[7:0];
      2'd1:    byte_sel = ram_rdata[15:8];
      2'd2:    byte_sel = ram_rdata[23:16];
      default: byte_sel = ram_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    ld_ext   = '0;
    if (lflag_q[LD_LB])       ld_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
    else if (lflag_q[LD_LH])  ld_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
    else if (lflag_q[LD_LW])  ld_ext = ram_rdata;
    else if (lflag_q[LD_LBU]) ld_ext = {{(XLEN-8){1'b0}}, byte_sel};
    else if (lflag_q[LD_LHU]) ld_ext = {{(XLEN-16){1'b0}}, half_sel};
  end

  always_comb begin
    state_d      = state_q;
    lflag_d      = lflag_q;
    lane_d       = lane_q;
    err_d        = err_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    dbg_valid_d  = 1'b0;
    dbg_data_d   = '0;
    ram_en       = 1'b0;
    ram_we       = '0;
    ram_addr     = cpu_idx;
    ram_wdata    = st_wdata;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ram_en = 1'b1;
          err_d  = misalign;
          lane_d = req_addr[1:0];
          if (dbg_rd_en) begin
            pend_d      = 1'b1;
            pend_addr_d = dbg_idx;
          end
          if (|store_flag) begin
            if (!misalign) ram_we = byte_en(store_flag, req_addr[1:0]);
            state_d = S_ST;
          end else if ((|load_flag) && !misalign) begin
            lflag_d = load_flag;
            state_d = S_LD;
          end else begin
            state_d = S_ST;
          end
        end else if (dbg_rd_en || pend_q) begin
          // A live request supersedes any older pending address
          ram_en   = 1'b1;
          ram_addr = dbg_rd_en ? dbg_idx : pend_addr_q;
          pend_d   = 1'b0;
          state_d  = S_DBG;
        end
      end
      S_LD: begin
        resp_valid_d = 1'b1;
        resp_data_d  = ld_ext;
        state_d      = S_IDLE;
      end
      S_ST: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        state_d      = S_IDLE;
      end
      default: begin
        dbg_valid_d = 1'b1;
        dbg_data_d  = ram_rdata;
        state_d     = S_IDLE;
      end
    endcase

    if ((state_q != S_IDLE) && dbg_rd_en) begin
      pend_d      = 1'b1;
      pend_addr_d = dbg_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lflag_q      <= '0;
      lane_q       <= '0;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      dbg_valid_q  <= 1'b0;
      dbg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      lflag_q      <= lflag_d;
      lane_q       <= lane_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      dbg_valid_q  <= dbg_valid_d;
      dbg_data_q   <= dbg_data_d;
    end
  end

  dmem_byte_ram #(
    .DATA_W (XLEN),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign req_ready    = rst && (state_q == S_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign dbg_rd_valid = dbg_valid_q;
  assign dbg_rd_data  = dbg_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : self-checking bench for dmem_responder
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [4:0]  load_flag = '0;
  logic [2:0]  store_flag = '0;
  logic [31:0] store_data = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        dbg_rd_en = 1'b0;
  logic [15:0] dbg_rd_addr = '0;
  logic        dbg_rd_valid;
  logic [31:0] dbg_rd_data;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [int];

  localparam logic [4:0] F_LB = 5'b00001, F_LH = 5'b00010, F_LW = 5'b00100,
                         F_LBU = 5'b01000, F_LHU = 5'b10000;
  localparam logic [2:0] F_SB = 3'b001, F_SH = 3'b010, F_SW = 3'b100;

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .DEPTH_LOG2(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .load_flag    (load_flag),
    .store_flag   (store_flag),
    .store_data   (store_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .dbg_rd_en    (dbg_rd_en),
    .dbg_rd_addr  (dbg_rd_addr),
    .dbg_rd_valid (dbg_rd_valid),
    .dbg_rd_data  (dbg_rd_data),
    .resp_err     (resp_err)
  );

  // Drives one request, waits for acceptance and records the response (no checking)
  task automatic do_req(input logic [4:0] lf, input logic [2:0] sf,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output bit ok, output int lat, output logic [31:0] d,
                        output logic e, output logic mid_rdy);
    int w;
    @(negedge clk);
    req_valid = 1'b1; load_flag = lf; store_flag = sf; req_addr = addr; store_data = wd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; load_flag = '0; store_flag = '0;
    ok = 0; lat = 0; d = 'x; e = 1'bx; mid_rdy = 1'bx;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) mid_rdy = req_ready;
      if (resp_valid && !ok) begin
        ok = 1; lat = n; d = resp_data; e = resp_err;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_data, dbg_rd_valid, dbg_rd_data, resp_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h dv=%b dd=%h err=%b, want all 0",
               req_ready, resp_valid, resp_data, dbg_rd_valid, dbg_rd_data, resp_err);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    bit ok; int lat; logic [31:0] d; logic e, mr; logic [31:0] exp;
    exp_q.push_back(32'h0);
    do_req(5'b0, F_SW, 32'h10, 32'hDEADBEEF, ok, lat, d, e, mr);
    exp = exp_q.pop_front();
    total++;
    if (!ok || d !== exp || lat != 2) begin
      bad++;
      $display("FAIL sw_resp: got ok=%0d lat=%0d data=%h want lat=2 data=%h", ok, lat, d, exp);
    end
    exp_q.push_back(32'hDEADBEEF);
    do_req(F_LW, 3'b0, 32'h10, 32'h0, ok, lat, d, e, mr);
    exp = exp_q.pop_front();
    total++;
    if (!ok || d !== exp || lat != 2) begin
      bad++;
      $display("FAIL lw_resp: got ok=%0d lat=%0d data=%h want lat=2 data=%h", ok, lat, d, exp);
    end
    total++;
    if (mr !== 1'b0) begin
      bad++;
      $display("FAIL lw_ready_busy: got %b want 0", mr);
    end
  endtask

  task automatic test_reset_mid_ld();
    bit ok; int lat; logic [31:0] d; logic e, mr; int pulses;
    @(negedge clk);
    req_valid = 1'b1; load_flag = F_LW; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0; load_flag = '0;
    rst = 1'b0;
    pulses = 0;
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_data, dbg_rd_valid, resp_err} !== '0) begin
      bad++;
      $display("FAIL midld_reset_outputs: got rdy=%b rv=%b rd=%h dv=%b err=%b want 0",
               req_ready, resp_valid, resp_data, dbg_rd_valid, resp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL midld_no_pulse: got %0d pulses want 0", pulses);
    end
    do_req(F_LW, 3'b0, 32'h10, 32'h0, ok, lat, d, e, mr);
    total++;
    if (!ok || d !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL midld_ram_kept: got ok=%0d data=%h want DEADBEEF", ok, d);
    end
  endtask

  task automatic test_byte_half();
    bit ok; int lat; logic [31:0] d; logic e, mr; logic [31:0] exp;
    logic [4:0]  lfs [5] = '{F_LB, F_LBU, F_LH, F_LHU, F_LW};
    logic [31:0] ads [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] exs [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AD, 32'h000080AD, 32'h80ADBEEF};
    exp_q.push_back(32'h0);
    do_req(5'b0, F_SB, 32'h13, 32'hAAAAAA80, ok, lat, d, e, mr);
    exp = exp_q.pop_front();
    total++;
    if (!ok || d !== exp) begin
      bad++;
      $display("FAIL sb_resp: got ok=%0d data=%h want %h", ok, d, exp);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exs[i]);
      do_req(lfs[i], 3'b0, ads[i], 32'h0, ok, lat, d, e, mr);
      exp = exp_q.pop_front();
      total++;
      if (!ok || d !== exp) begin
        bad++;
        $display("FAIL load_ext[%0d]: got ok=%0d data=%h want %h", i, ok, d, exp);
      end
    end
  endtask

  task automatic test_dbg_arb();
    bit ok; int lat; logic [31:0] d; logic e, mr;
    int cpu_at, dbg_at, dbg_cnt;
    logic [31:0] dbg_got;
    do_req(5'b0, F_SW, 32'h20, 32'h12345678, ok, lat, d, e, mr);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      req_valid = 1'b1; load_flag = F_LW; req_addr = 32'h20;
      dbg_rd_en = 1'b1; dbg_rd_addr = (pass == 0) ? 16'd4 : 16'd8;
      exp_q.push_back(32'h12345678);
      @(posedge clk);
      #1;
      req_valid = 1'b0; load_flag = '0; dbg_rd_en = 1'b0;
      cpu_at = 0; dbg_at = 0; dbg_cnt = 0; dbg_got = 'x;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (n == 1 && pass == 1) begin
          dbg_rd_en = 1'b1; dbg_rd_addr = 16'd4;
        end
        if (n == 2) dbg_rd_en = 1'b0;
        if (resp_valid && cpu_at == 0) begin
          cpu_at = n;
          d = resp_data;
        end
        if (dbg_rd_valid) begin
          dbg_cnt++;
          dbg_at = n;
          dbg_got = dbg_rd_data;
        end
      end
      total++;
      if (cpu_at != 2 || d !== exp_q.pop_front()) begin
        bad++;
        $display("FAIL dbg_arb_cpu[%0d]: got at=%0d data=%h want at=2 data=12345678", pass, cpu_at, d);
      end
      total++;
      if (dbg_cnt != 1 || dbg_got !== 32'h80ADBEEF || dbg_at <= cpu_at) begin
        bad++;
        $display("FAIL dbg_arb_dbg[%0d]: got cnt=%0d at=%0d data=%h want cnt=1 after cpu data=80ADBEEF",
                 pass, dbg_cnt, dbg_at, dbg_got);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok; int lat; logic [31:0] d; logic e, mr; int w;
    do_req(5'b0, F_SW, 32'h0, 32'hCAFEF00D, ok, lat, d, e, mr);
    exp_q.push_back(32'hCAFEF00D);
    do_req(F_LW, 3'b0, 32'h4000, 32'h0, ok, lat, d, e, mr);
    total++;
    if (!ok || d !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL wrap_lw: got ok=%0d data=%h want CAFEF00D", ok, d);
    end
    @(negedge clk);
    dbg_rd_en = 1'b1; dbg_rd_addr = 16'h0400;
    @(posedge clk);
    #1;
    dbg_rd_en = 1'b0;
    w = 0;
    d = 'x;
    while (w < 8) begin
      @(negedge clk);
      w++;
      if (dbg_rd_valid) begin
        d = dbg_rd_data;
        break;
      end
    end
    total++;
    if (d !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL wrap_dbg: got %h want CAFEF00D", d);
    end
  endtask

  task automatic test_misalign();
    bit ok; int lat; logic [31:0] d; logic e, mr; logic exp_err; logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_CHK_EN
    exp_err = 1'b1; exp_word = 32'h80ADBEEF;
`else
    exp_err = 1'b0; exp_word = 32'h80AD1234;
`endif
    do_req(5'b0, F_SH, 32'h11, 32'h00001234, ok, lat, d, e, mr);
    total++;
    if (!ok || d !== 32'h0 || e !== exp_err) begin
      bad++;
      $display("FAIL misalign_sh: got ok=%0d data=%h err=%b want data=0 err=%b", ok, d, e, exp_err);
    end
    exp_q.push_back(exp_word);
    do_req(F_LW, 3'b0, 32'h10, 32'h0, ok, lat, d, e, mr);
    total++;
    if (!ok || d !== exp_q.pop_front() || e !== 1'b0) begin
      bad++;
      $display("FAIL misalign_word: got data=%h err=%b want %h err=0", d, e, exp_word);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  sfs [8];
    logic [4:0]  lfs [8];
    logic [31:0] ads [8];
    logic [31:0] wds [8];
    int idx, last_acc, gaps_bad, got;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      ads[i] = 32'h100 + 32'((i % 4) * 4);
      wds[i] = $urandom;
      sfs[i] = (i < 4) ? F_SW : 3'b0;
      lfs[i] = (i < 4) ? 5'b0 : F_LW;
    end
    idx = 0; last_acc = -1; gaps_bad = 0; got = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        got++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        total++;
        if (resp_data !== exp) begin
          bad++;
          $display("FAIL b2b_resp[%0d]: got %h want %h", got, resp_data, exp);
        end
      end
      if (idx < 8) begin
        req_valid = 1'b1; store_flag = sfs[idx]; load_flag = lfs[idx];
        req_addr = ads[idx]; store_data = wds[idx];
        if (req_ready) begin
          if (sfs[idx] != 0) begin
            model[int'(ads[idx] >> 2)] = wds[idx];
            exp_q.push_back(32'h0);
          end else begin
            exp_q.push_back(model[int'(ads[idx] >> 2)]);
          end
          if (last_acc >= 0 && cyc - last_acc != 2) gaps_bad++;
          last_acc = cyc;
          idx++;
        end
      end else begin
        req_valid = 1'b0; store_flag = '0; load_flag = '0;
        if (exp_q.size() == 0) break;
      end
    end
    total++;
    if (got != 8 || idx != 8) begin
      bad++;
      $display("FAIL b2b_count: got %0d resp %0d accepted want 8", got, idx);
    end
    total++;
    if (gaps_bad != 0) begin
      bad++;
      $display("FAIL b2b_throughput: %0d accept gaps not equal to 2 cycles", gaps_bad);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_reset_mid_ld();
    test_byte_half();
    test_dbg_arb();
    test_wrap();
    test_misalign();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
